// File: rtl/instr_prefetch_if.sv
// Instruction prefetch bus bundle.
// Groups the memory fetch port (req/addr/ack/rdata), the branch redirect
// inputs and the IF-side queue head (valid/instr/pc_plus4/ready/count).
// master: the prefetch buffer itself; slave: memory, ID and IF side.
interface instr_prefetch_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             mem_req_o;
    logic [31:0]      mem_addr_o;
    logic             mem_ack_i;
    logic [31:0]      mem_rdata_i;
    logic             redirect_i;
    logic [31:0]      redirect_pc_i;
    logic             instr_valid_o;
    logic [31:0]      instr_o;
    logic [31:0]      pc_plus4_o;
    logic             instr_ready_i;
    logic [CNT_W-1:0] count_o;

    modport master (
        output mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_plus4_o, count_o,
        input  mem_ack_i, mem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_plus4_o, count_o,
        output mem_ack_i, mem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
    );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer.
// Issues sequential word fetches (one outstanding at a time) to instruction
// memory and queues up to DEPTH {instr, pc+4} pairs for the IF stage. A branch
// redirect from ID empties the queue and restarts fetching at the target; a
// request already in flight at that moment is completed and its data dropped.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active low
//   bus  - instr_prefetch_if.master (memory port, redirect, IF queue head)
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic              clk,
    input logic              rst,
    instr_prefetch_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [31:0]      fetch_pc_r, fetch_pc_nxt_s;
    logic [31:0]      addr_r, addr_nxt_s;
    logic             req_r, req_nxt_s;
    logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic [31:0]      instr_mem_r [DEPTH];
    logic [31:0]      pcp4_mem_r  [DEPTH];

    logic             valid_s, pop_s, push_s, flush_s;
    logic             free_after_pop_s, free_after_push_s;
    logic [31:0]      redirect_pc_s;
    logic [CNT_W-1:0] depth_s;

    assign depth_s       = CNT_W'(DEPTH);
    assign redirect_pc_s = bus.redirect_pc_i & 32'hFFFF_FFFC;
    assign flush_s       = bus.redirect_i;
    assign valid_s       = (count_r != {CNT_W{1'b0}});
    // Redirect wins over a pop, so a pop is never applied while flushing.
    assign pop_s         = valid_s & bus.instr_ready_i & ~bus.redirect_i;
    // Space checks use the occupancy after this cycle's pop (and push).
    assign free_after_pop_s  = ((count_r - CNT_W'(pop_s)) < depth_s);
    assign free_after_push_s = ((count_r + CNT_W'(1'b1) - CNT_W'(pop_s)) < depth_s);

    assign bus.mem_req_o     = req_r;
    assign bus.mem_addr_o    = addr_r;
    assign bus.count_o       = count_r;
    assign bus.instr_valid_o = valid_s;
    assign bus.instr_o       = valid_s ? instr_mem_r[rd_ptr_r] : 32'h0000_0000;
    assign bus.pc_plus4_o    = valid_s ? pcp4_mem_r[rd_ptr_r]  : 32'h0000_0000;

    // Fetch FSM next state, next fetch address and next request outputs
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        req_nxt_s      = req_r;
        addr_nxt_s     = addr_r;
        push_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.redirect_i) begin
                    state_nxt_s    = ST_REQ;
                    fetch_pc_nxt_s = redirect_pc_s;
                    req_nxt_s      = 1'b1;
                    addr_nxt_s     = redirect_pc_s;
                end else if (free_after_pop_s) begin
                    state_nxt_s = ST_REQ;
                    req_nxt_s   = 1'b1;
                    addr_nxt_s  = fetch_pc_r;
                end else begin
                    req_nxt_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (bus.mem_ack_i && bus.redirect_i) begin
                    // Data for the old stream arrives with the redirect: drop it.
                    fetch_pc_nxt_s = redirect_pc_s;
                    req_nxt_s      = 1'b1;
                    addr_nxt_s     = redirect_pc_s;
                end else if (bus.mem_ack_i) begin
                    push_s         = 1'b1;
                    fetch_pc_nxt_s = fetch_pc_r + 32'd4;
                    addr_nxt_s     = fetch_pc_r + 32'd4;
                    if (free_after_push_s) begin
                        req_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        req_nxt_s   = 1'b0;
                    end
                end else if (bus.redirect_i) begin
                    // Memory still owes an answer; keep the request up and discard it later.
                    state_nxt_s    = ST_DROP;
                    fetch_pc_nxt_s = redirect_pc_s;
                end else begin
                    req_nxt_s = 1'b1;
                end
            end
            ST_DROP: begin
                if (bus.mem_ack_i) begin
                    state_nxt_s    = ST_REQ;
                    fetch_pc_nxt_s = bus.redirect_i ? redirect_pc_s : fetch_pc_r;
                    req_nxt_s      = 1'b1;
                    addr_nxt_s     = bus.redirect_i ? redirect_pc_s : fetch_pc_r;
                end else if (bus.redirect_i) begin
                    fetch_pc_nxt_s = redirect_pc_s;
                end else begin
                    req_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                req_nxt_s   = 1'b0;
            end
        endcase
    end

    // Queue occupancy after this cycle's push, pop or flush
    always_comb begin
        if (flush_s) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else begin
            count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Fetch FSM state, fetch address and registered memory request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_r      <= 1'b0;
            addr_r     <= RESET_PC;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            req_r      <= req_nxt_s;
            addr_r     <= addr_nxt_s;
        end
    end

    // Queue storage, read/write pointers and occupancy register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_r[i] <= 32'h0000_0000;
                pcp4_mem_r[i]  <= 32'h0000_0000;
            end
        end else begin
            count_r <= count_nxt_s;
            if (flush_s) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_s) begin
                    instr_mem_r[wr_ptr_r] <= bus.mem_rdata_i;
                    pcp4_mem_r[wr_ptr_r]  <= fetch_pc_r + 32'd4;
                    wr_ptr_r              <= wr_ptr_r + PTR_W'(1'b1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: directed scenarios followed by
// a randomized phase, all checked against a transaction-level reference model
// (a queue of {instr, pc+4} plus the outstanding memory request).
module tb_instr_prefetch_buffer;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    instr_prefetch_if #(.DEPTH(DEPTH)) bus ();

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [63:0] m_q[$];     // {instr, pc_plus4}
    logic        m_req;      // request visible on the memory port
    logic [31:0] m_addr;     // its address
    logic        m_stale;    // outstanding request belongs to a flushed stream
    logic [31:0] m_fetch;    // next address to request
    int          m_age;      // cycles the current request has been waiting

    task automatic model_reset();
        m_q.delete();
        m_req   = 1'b0;
        m_addr  = 32'h0;
        m_stale = 1'b0;
        m_fetch = 32'h0;
        m_age   = 0;
    endtask

    task automatic model_update(input logic ack, input logic [31:0] rdata,
                                input logic redir, input logic [31:0] rpc, input logic ready);
        logic pop;
        pop = (m_q.size() > 0) && ready;
        if (redir) begin
            m_q.delete();
            m_fetch = rpc & 32'hFFFF_FFFC;
            if (m_req && !ack) begin
                m_stale = 1'b1;
                m_age++;
            end else begin
                m_req   = 1'b1;
                m_addr  = m_fetch;
                m_stale = 1'b0;
                m_age   = 0;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_req && ack) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_addr  = m_fetch;
                    m_age   = 0;
                end else begin
                    m_q.push_back({rdata, m_addr + 32'd4});
                    m_fetch = m_addr + 32'd4;
                    if (m_q.size() < DEPTH) begin
                        m_addr = m_fetch;
                        m_age  = 0;
                    end else begin
                        m_req = 1'b0;
                    end
                end
            end else if (m_req) begin
                m_age++;
            end else if (m_q.size() < DEPTH) begin
                m_req  = 1'b1;
                m_addr = m_fetch;
                m_age  = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [63:0] head;
        chk("mem_req", {31'd0, bus.mem_req_o}, {31'd0, m_req});
        if (m_req) chk("mem_addr", bus.mem_addr_o, m_addr);
        chk("count", {29'd0, bus.count_o}, 32'(m_q.size()));
        chk("valid", {31'd0, bus.instr_valid_o}, {31'd0, (m_q.size() > 0)});
        if (m_q.size() > 0) begin
            head = m_q[0];
            chk("instr", bus.instr_o, head[63:32]);
            chk("pc_plus4", bus.pc_plus4_o, head[31:0]);
        end
    endtask

    // One clock cycle: memory acks once the request has waited 'delay' cycles.
    task automatic step(input int delay, input logic redir, input logic [31:0] rpc, input logic ready);
        logic        ack;
        logic [31:0] rdata;
        ack   = m_req && (m_age >= delay);
        rdata = $urandom();
        bus.mem_ack_i     = ack;
        bus.mem_rdata_i   = rdata;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = rpc;
        bus.instr_ready_i = ready;
        @(posedge clk);
        if (rst) model_update(ack, rdata, redir, rpc, ready);
        else     model_reset();
        #1;
        check_all();
    endtask

    initial begin
        logic found;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        bus.mem_ack_i     = 1'b0;
        bus.mem_rdata_i   = 32'h0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.instr_ready_i = 1'b0;
        model_reset();

        // Reset state
        step(0, 1'b0, 32'h0, 1'b0);
        step(0, 1'b0, 32'h0, 1'b0);
        chk("rst_addr", bus.mem_addr_o, 32'h0);
        chk("rst_instr", bus.instr_o, 32'h0);
        chk("rst_pc4", bus.pc_plus4_o, 32'h0);

        // 1: streaming, ack one cycle after each request
        rst = 1'b1;
        step(1, 1'b0, 32'h0, 1'b1);
        chk("t1_first_req", bus.mem_addr_o, 32'h0);
        for (int i = 0; i < 16; i++) step(1, 1'b0, 32'h0, 1'b1);

        // 2: IF stalled, queue fills, then a single pop reopens fetching
        step(0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) step(0, 1'b0, 32'h0, 1'b0);
        chk("t2_full_count", {29'd0, bus.count_o}, 32'd4);
        chk("t2_full_noreq", {31'd0, bus.mem_req_o}, 32'd0);
        step(0, 1'b0, 32'h0, 1'b1);
        chk("t2_pop_count", {29'd0, bus.count_o}, 32'd3);
        chk("t2_req_0x10", bus.mem_addr_o, 32'h10);

        // 3: redirect while a slow request is pending goes through DROP
        step(3, 1'b1, 32'h0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_req && !m_stale && m_addr == 32'h8 && m_age == 0) found = 1'b1;
            else step(3, 1'b0, 32'h0, 1'b1);
        end
        chk("t3_reach_req8", {31'd0, found}, 32'd1);
        step(3, 1'b1, 32'h42, 1'b1);
        chk("t3_valid_off", {31'd0, bus.instr_valid_o}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(3, 1'b0, 32'h0, 1'b0);
            found = bus.instr_valid_o;
        end
        chk("t3_got_instr", {31'd0, found}, 32'd1);
        chk("t3_first_pc4", bus.pc_plus4_o, 32'h44);

        // 4: redirect coinciding with ack and pop at count=2
        step(0, 1'b1, 32'h200, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_q.size() == 2 && m_req) found = 1'b1;
            else step(0, 1'b0, 32'h0, 1'b0);
        end
        chk("t4_reach_cnt2", {31'd0, found}, 32'd1);
        step(0, 1'b1, 32'h101, 1'b1);
        chk("t4_count0", {29'd0, bus.count_o}, 32'd0);
        chk("t4_req_0x100", bus.mem_addr_o, 32'h100);

        // 5: push and pop together at count=3, pointers wrap
        step(0, 1'b1, 32'h300, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_q.size() == 3 && m_req) found = 1'b1;
            else step(0, 1'b0, 32'h0, 1'b0);
        end
        chk("t5_reach_cnt3", {31'd0, found}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            step(0, 1'b0, 32'h0, 1'b1);
            chk("t5_count3", {29'd0, bus.count_o}, 32'd3);
        end

        // 6: asynchronous reset in the middle of a request
        step(5, 1'b0, 32'h0, 1'b0);
        chk("t6_req_before", {31'd0, bus.mem_req_o}, 32'd1);
        rst = 1'b0;
        #2;
        model_reset();
        chk("t6_req_off", {31'd0, bus.mem_req_o}, 32'd0);
        chk("t6_count0", {29'd0, bus.count_o}, 32'd0);
        chk("t6_valid_off", {31'd0, bus.instr_valid_o}, 32'd0);
        rst = 1'b1;
        step(1, 1'b0, 32'h0, 1'b1);
        chk("t6_refetch", bus.mem_addr_o, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(int'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0),
                 $urandom(), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
